// File: rtl/kuznechik_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kuznechik_pkg
// Purpose  : Shared types and constants for the kuznechik core arbitration.
// Revision : 1.0 - initial release
// ============================================================================
package kuznechik_pkg;

    localparam int BLOCK_W                = 128;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/kuznechik_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : kuznechik_rr_pick
// Purpose  : Combinational round-robin picker; first valid index after
//            i_last_grant, wrapping around.
// Revision : 1.0 - initial release
// ============================================================================
module kuznechik_rr_pick #(
    parameter int N_REQ = 2,
    parameter int ID_W  = (N_REQ <= 2) ? 1 : $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]  i_last_grant,
    output logic             o_any,
    output logic [ID_W-1:0]  o_grant_idx,
    output logic [N_REQ-1:0] o_grant_oh
);

    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_any       = 1'b0;
        o_grant_idx = '0;
        o_grant_oh  = '0;
        w_idx       = '0;
        // Candidate order starts one past the previous winner.
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = ID_W'((int'(i_last_grant) + k) % N_REQ);
            if (!o_any && i_valid[w_idx]) begin
                o_any       = 1'b1;
                o_grant_idx = w_idx;
                o_grant_oh  = N_REQ'(1) << w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/kuznechik_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : kuznechik_req_arbiter
// Purpose  : Round-robin sharing of one kuznechik_cipher core between N_REQ
//            requesters; one block in flight, results tagged with owner id.
//            Optional WAIT watchdog enabled by macro KUZ_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module kuznechik_req_arbiter
    import kuznechik_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int ID_W           = (N_REQ <= 2) ? 1 : $clog2(N_REQ),
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*BLOCK_W-1:0] req_data_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [ID_W-1:0]          res_id_o,
    output logic [BLOCK_W-1:0]       res_data_o,
    output logic                     core_request_o,
    output logic                     core_ack_o,
    output logic [BLOCK_W-1:0]       core_data_o,
    input  logic                     core_busy_i,
    input  logic                     core_valid_i,
    input  logic [BLOCK_W-1:0]       core_data_i,
    output logic                     err_o
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("kuznechik_req_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
    end

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_res_id;
    logic [BLOCK_W-1:0]  r_core_data;
    logic [BLOCK_W-1:0]  r_res_data;

    logic                w_any;
    logic [ID_W-1:0]     w_grant_idx;
    logic [N_REQ-1:0]    w_grant_oh;
    logic                w_grant;
    logic                w_timeout;
    logic [BLOCK_W-1:0]  w_sel_data;

    kuznechik_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .i_valid      (req_valid_i),
        .i_last_grant (r_last_grant),
        .o_any        (w_any),
        .o_grant_idx  (w_grant_idx),
        .o_grant_oh   (w_grant_oh)
    );

    // A core still busy or holding a result must not be handed a new block.
    assign w_grant = (r_state == IDLE) && w_any && !core_busy_i && !core_valid_i;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_data = req_data_i[i*BLOCK_W +: BLOCK_W];
            end
        end
    end

`ifdef KUZ_ARB_TIMEOUT_EN
    localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wait_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == WAIT) && !core_valid_i &&
                       (r_wait_cnt == C_CNT_W'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_last_grant <= ID_W'(N_REQ - 1);
            r_res_id     <= '0;
            r_core_data  <= '0;
            r_res_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_core_data <= w_sel_data;
                        r_res_id    <= w_grant_idx;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (core_valid_i) begin
                        r_res_data <= core_data_i;
                        r_state    <= DELIVER;
                    end else if (w_timeout) begin
                        r_last_grant <= r_res_id;
                        r_state      <= IDLE;
                    end
                end
                DELIVER: begin
                    if (res_ready_i) begin
                        r_last_grant <= r_res_id;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reset gates the grant so no block is taken while reset is held.
    assign req_ready_o    = (w_grant && !rst_i) ? w_grant_oh : '0;
    assign core_request_o = (r_state == ISSUE);
    assign core_ack_o     = (r_state == WAIT) && (core_valid_i || w_timeout);
    assign core_data_o    = r_core_data;
    assign res_valid_o    = (r_state == DELIVER);
    assign res_id_o       = r_res_id;
    assign res_data_o     = r_res_data;
    assign err_o          = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_kuznechik_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_kuznechik_req_arbiter
// Purpose  : Scoreboard bench for kuznechik_req_arbiter with a behavioural
//            cipher-core model; timeout cases built with KUZ_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kuznechik_req_arbiter;

    localparam int          LAT     = 10;
    localparam logic [127:0] GOST_PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] GOST_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;

    typedef struct packed {
        logic         id;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid, req_ready;
    logic [255:0] req_data;
    logic         res_valid, res_ready, res_id;
    logic [127:0] res_data;
    logic         core_request, core_ack, core_busy, core_valid, err;
    logic [127:0] core_din, core_dout;

    logic         m_busy, m_valid, dead, force_busy, force_valid;
    int           m_cnt;
    logic [127:0] m_in, m_out;

    logic [127:0] rq0[$];
    logic [127:0] rq1[$];
    exp_t         exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_cnt = 0;
    logic err_seen = 1'b0;

    always #5 clk = ~clk;

    kuznechik_req_arbiter #(
        .N_REQ          (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_data_i     (req_data),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_id_o       (res_id),
        .res_data_o     (res_data),
        .core_request_o (core_request),
        .core_ack_o     (core_ack),
        .core_data_o    (core_din),
        .core_busy_i    (core_busy),
        .core_valid_i   (core_valid),
        .core_data_i    (core_dout),
        .err_o          (err)
    );

    function automatic logic [127:0] core_fn(input logic [127:0] x);
        if (x == GOST_PT) return GOST_CT;
        return {x[63:0], x[127:64]} ^ 128'h5a5a5a5a_0f0f0f0f_a5a5a5a5_f0f0f0f0;
    endfunction

    // Behavioural cipher core: LAT cycles busy, then valid held until ack.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_in    <= '0;
            m_out   <= '0;
        end else begin
            if (core_ack) m_valid <= 1'b0;
            if (core_request && !dead) begin
                m_busy <= 1'b1;
                m_cnt  <= LAT;
                m_in   <= core_din;
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b1;
                    m_out   <= core_fn(m_in);
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign core_busy  = m_busy | force_busy;
    assign core_valid = m_valid | force_valid;
    assign core_dout  = m_out;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired got timeout expected event", nm);
    endtask

    task automatic push(input int r, input logic [127:0] d);
        if (r == 0) rq0.push_back(d);
        else        rq1.push_back(d);
    endtask

    task automatic expect_res(input logic id, input logic [127:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            #3;
            if (rq0.size() == 0 && rq1.size() == 0 && exp_q.size() == 0 && !res_valid)
                done = 1'b1;
        end
        if (!done) bound_fail(nm);
    endtask

    // Requester driver: drive on negedge, note acceptance, pop one cycle later.
    initial begin : p_driver
        logic [1:0] acc;
        acc       = 2'b00;
        req_valid = 2'b00;
        req_data  = '0;
        forever begin
            @(negedge clk);
            if (acc[0] && rq0.size() > 0) void'(rq0.pop_front());
            if (acc[1] && rq1.size() > 0) void'(rq1.pop_front());
            req_valid[0]      = (rq0.size() > 0);
            req_valid[1]      = (rq1.size() > 0);
            req_data[127:0]   = (rq0.size() > 0) ? rq0[0] : '0;
            req_data[255:128] = (rq1.size() > 0) ? rq1[0] : '0;
            #1;
            acc = req_ready;
        end
    end

    // Result monitor: compare each completed result handshake to the scoreboard.
    initial begin : p_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (core_ack) ack_cnt++;
            if (err) err_seen = 1'b1;
            if (!rst && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {3'b0, res_id, res_data}, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {3'b0, res_id, res_data}, {3'b0, e.id, e.data});
                end
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : p_main
        int   t_rdy, t_req, t_err, n_reqp, n_errp, ack0;
        logic [1:0] rdy_val;
        logic ack_at_err, rv_seen, seen;

        rst = 1'b1; res_ready = 1'b1; dead = 1'b0;
        force_busy = 1'b0; force_valid = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_core_request", core_request, 0);
        chk("rst_core_ack", core_ack, 0);
        chk("rst_core_data", core_din, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single GOST block from requester 0.
        push(0, GOST_PT);
        expect_res(1'b0, GOST_CT);
        t_rdy = -1; t_req = -1; n_reqp = 0; rdy_val = 2'b00; ack0 = ack_cnt;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #3;
            if (req_ready != 2'b00 && t_rdy < 0) begin
                t_rdy   = cyc;
                rdy_val = req_ready;
            end
            if (core_request) begin
                n_reqp++;
                if (t_req < 0) t_req = cyc;
            end
        end
        chk("t1_ready_onehot", rdy_val, 2'b01);
        chk("t1_request_latency", t_req - t_rdy, 1);
        chk("t1_request_pulses", n_reqp, 1);
        chk("t1_ack_pulses", ack_cnt - ack0, 1);
        chk("t1_delivered", exp_q.size(), 0);

        // Reset mid-WAIT with blocks queued for the round-robin run.
        push(1, 128'hdeadbeef_00000000_cafef00d_11111111);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #3;
            if (core_request) seen = 1'b1;
        end
        if (!seen) bound_fail("t4_issue");
        for (int k = 0; k < 3; k++) begin
            push(0, 128'h00000000_00000000_00000000_000000a0 + 128'(k));
            push(1, 128'h00000000_00000000_00000000_000000b0 + 128'(k));
            expect_res(1'b0, core_fn(128'h00000000_00000000_00000000_000000a0 + 128'(k)));
            expect_res(1'b1, core_fn(128'h00000000_00000000_00000000_000000b0 + 128'(k)));
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #3;
        chk("t4_req_ready", req_ready, 0);
        chk("t4_res_valid", res_valid, 0);
        chk("t4_res_id", res_id, 0);
        chk("t4_res_data", res_data, 0);
        chk("t4_core_request", core_request, 0);
        chk("t4_core_ack", core_ack, 0);
        chk("t4_core_data", core_din, 0);
        chk("t4_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_drain("t2_round_robin", 300);

        // Backpressure in DELIVER.
        @(negedge clk);
        res_ready = 1'b0;
        push(0, 128'h0123456789abcdef_fedcba9876543210);
        push(1, 128'h55555555_66666666_77777777_88888888);
        expect_res(1'b0, core_fn(128'h0123456789abcdef_fedcba9876543210));
        expect_res(1'b1, core_fn(128'h55555555_66666666_77777777_88888888));
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            #3;
            if (res_valid) seen = 1'b1;
        end
        if (!seen) bound_fail("t3_deliver");
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", res_valid, 1);
            chk("t3_hold_id", res_id, 0);
            chk("t3_hold_data", res_data, core_fn(128'h0123456789abcdef_fedcba9876543210));
            chk("t3_no_request", core_request, 0);
            chk("t3_no_ready", req_ready, 0);
            @(negedge clk);
            if (k != 4) #3;
        end
        res_ready = 1'b1;
        wait_drain("t3_drain", 100);

        // Core busy, then a stray core valid, while both requesters wait.
        @(negedge clk);
        force_busy = 1'b1;
        push(0, 128'hc0c0c0c0_c0c0c0c0_c0c0c0c0_c0c0c0c0);
        push(1, 128'hd1d1d1d1_d1d1d1d1_d1d1d1d1_d1d1d1d1);
        expect_res(1'b0, core_fn(128'hc0c0c0c0_c0c0c0c0_c0c0c0c0_c0c0c0c0));
        expect_res(1'b1, core_fn(128'hd1d1d1d1_d1d1d1d1_d1d1d1d1_d1d1d1d1));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #3;
            chk("t5_busy_no_ready", req_ready, 0);
        end
        @(negedge clk);
        force_busy  = 1'b0;
        force_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("t5_stray_valid_no_ready", req_ready, 0);
            chk("t5_stray_valid_no_ack", core_ack, 0);
            @(negedge clk);
        end
        force_valid = 1'b0;
        #3;
        chk("t5_grant0", req_ready, 2'b01);
        wait_drain("t5_drain", 100);

`ifdef KUZ_ARB_TIMEOUT_EN
        // Dead core: watchdog fires, then requester 1 is served first.
        @(negedge clk);
        dead = 1'b1;
        push(0, 128'heeeeeeee_eeeeeeee_eeeeeeee_eeeeeeee);
        t_req = -1; t_err = -1; n_errp = 0; ack_at_err = 1'b0; rv_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #3;
            if (core_request && t_req < 0) t_req = cyc;
            if (err) begin
                n_errp++;
                if (t_err < 0) begin
                    t_err      = cyc;
                    ack_at_err = core_ack;
                end
            end
            if (res_valid) rv_seen = 1'b1;
        end
        chk("t6_err_delay", t_err - t_req, 17);
        chk("t6_err_pulses", n_errp, 1);
        chk("t6_ack_with_err", ack_at_err, 1);
        chk("t6_no_result", rv_seen, 0);
        @(negedge clk);
        dead = 1'b0;
        push(0, 128'h0000000f_0000000f_0000000f_0000000f);
        push(1, 128'h0000001e_0000001e_0000001e_0000001e);
        expect_res(1'b1, core_fn(128'h0000001e_0000001e_0000001e_0000001e));
        expect_res(1'b0, core_fn(128'h0000000f_0000000f_0000000f_0000000f));
        wait_drain("t6_drain", 100);
`else
        chk("err_tied_low", err_seen, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
